// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with hardwired zero register.
//   NRD combinational read ports with same-cycle write bypass (port 1 beats
//   port 0), two write ports, RAM-mappable storage (never bulk-reset) cleared
//   after reset by a one-entry-per-cycle sequencer, and a registered debug
//   read port.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ra / rd_data      NRD packed read addresses / combinational read data
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1
//   busy              clear sequencer active; writes are dropped
//   wr_drop           registered pulse: a nonzero-address write was discarded
//   dbg_addr/dbg_data debug read address / registered bypassed read value
module regfile_mp #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRD   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  output logic                busy,
  output logic                wr_drop,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              wr_drop_q, wr_drop_d;
  logic [XLEN-1:0]   dbg_data_q, dbg_data_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              ready;
  logic              accept;
  logic              we0_req, we1_req;
  logic              we0_eff, we1_eff;
  logic              clr_we;

  // Read addresses for all ports; the extra last slot is the debug port.
  logic [AW-1:0]     rd_addr [NRD+1];
  logic [XLEN-1:0]   rd_val  [NRD+1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(NREGS - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == CLEAR);
    ready = (state_q == READY);
  end

  // Writes to r0 are neither performed nor counted as dropped.
  assign we0_req = we0 && (wa0 != '0);
  assign we1_req = we1 && (wa1 != '0);
  assign accept  = ready && !reset;
  assign we0_eff = we0_req && accept;
  assign we1_eff = we1_req && accept;
  assign clr_we  = busy && !reset;

  // Storage: no reset so it maps onto RAM; port 1 written last so it wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      if (we0_eff) mem_q[wa0] <= wd0;
      if (we1_eff) mem_q[wa1] <= wd1;
    end
  end

  // Bypassed reads; everything reads 0 while clearing since storage is stale.
  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) rd_addr[k] = ra[k*AW +: AW];
    rd_addr[NRD] = dbg_addr;
    for (int unsigned k = 0; k <= NRD; k++) begin
      rd_val[k] = '0;
      if (ready && (rd_addr[k] != '0)) begin
        if (we1_eff && (wa1 == rd_addr[k]))      rd_val[k] = wd1;
        else if (we0_eff && (wa0 == rd_addr[k])) rd_val[k] = wd0;
        else                                     rd_val[k] = mem_q[rd_addr[k]];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) rd_data[k*XLEN +: XLEN] = rd_val[k];
  end

  assign wr_drop_d  = (we0_req || we1_req) && !accept;
  assign dbg_data_d = rd_val[NRD];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_drop_q  <= wr_drop_d;
      dbg_data_q <= '0;
    end else begin
      wr_drop_q  <= wr_drop_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign wr_drop  = wr_drop_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                busy, wr_drop;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd_data(rd_data),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .busy(busy), .wr_drop(wr_drop), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rd(input int unsigned k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  // Runs cycles 1..NREGS after reset release; busy must hold exactly NREGS-1 cycles.
  task automatic run_clear(input logic poke_r7);
    for (int c = 1; c <= NREGS; c++) begin
      set_ra(AW'(c), AW'(NREGS - 1 - c));
      if (poke_r7 && c == 3) begin
        we0 = 1'b1; wa0 = 5'd7; wd0 = 64'h77;
      end
      if (poke_r7 && c == 4) we0 = 1'b0;
      #1;
      if (c <= NREGS - 1) begin
        chk($sformatf("busy_c%0d", c), {63'd0, busy}, 64'd1);
        chk($sformatf("rd0_clr_c%0d", c), rd(0), 64'd0);
        chk($sformatf("rd1_clr_c%0d", c), rd(1), 64'd0);
      end else begin
        chk("busy_done", {63'd0, busy}, 64'd0);
      end
      if (poke_r7 && c == 4) chk("wr_drop_c4", {63'd0, wr_drop}, 64'd1);
      if (poke_r7 && c == 5) chk("wr_drop_c5", {63'd0, wr_drop}, 64'd0);
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; ra = '0; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; dbg_addr = '0;
    next_cycle();
    next_cycle();
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_wr_drop", {63'd0, wr_drop}, 64'd0);
    chk("rst_dbg", dbg_data, 64'd0);

    reset = 1'b0;
    run_clear(1'b1);

    // r7 write during clear must have been discarded
    set_ra(5'd7, 5'd0);
    #1 chk("r7_after_clear", rd(0), 64'd0);

    // bypass then storage for r12
    we0 = 1'b1; wa0 = 5'd12; wd0 = 64'h12; set_ra(5'd3, 5'd12);
    #1 chk("r12_bypass", rd(1), 64'h12);
    chk("r3_untouched", rd(0), 64'd0);
    next_cycle();
    we0 = 1'b0;
    #1 chk("r12_stored", rd(1), 64'h12);

    // same-address dual write: port 1 wins
    we0 = 1'b1; wa0 = 5'd5; wd0 = 64'hAA;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 64'hBB; set_ra(5'd5, 5'd12);
    #1 chk("r5_bypass_p1", rd(0), 64'hBB);
    chk("r12_during_w5", rd(1), 64'h12);
    next_cycle();
    we0 = 1'b0; we1 = 1'b0;
    #1 chk("r5_stored", rd(0), 64'hBB);
    chk("wr_drop_ready", {63'd0, wr_drop}, 64'd0);

    // writes to r0 are ignored and not flagged
    we0 = 1'b1; wa0 = 5'd0; wd0 = 64'hFFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 64'hFFFF; set_ra(5'd0, 5'd0);
    #1 chk("r0_bypass_p0", rd(0), 64'd0);
    chk("r0_bypass_p1", rd(1), 64'd0);
    next_cycle();
    we0 = 1'b0; we1 = 1'b0;
    #1 chk("r0_stored", rd(0), 64'd0);
    chk("r0_no_drop", {63'd0, wr_drop}, 64'd0);

    // debug port
    we0 = 1'b1; wa0 = 5'd13; wd0 = 64'd13; dbg_addr = 5'd5;
    next_cycle();
    chk("dbg_r5", dbg_data, 64'hBB);
    we0 = 1'b0; dbg_addr = 5'd13;
    next_cycle();
    chk("dbg_r13", dbg_data, 64'd13);
    // debug sees bypass from port 1
    we1 = 1'b1; wa1 = 5'd9; wd1 = 64'h99; dbg_addr = 5'd9;
    next_cycle();
    we1 = 1'b0;
    chk("dbg_bypass_r9", dbg_data, 64'h99);

    // reset mid-operation
    dbg_addr = 5'd13; set_ra(5'd13, 5'd9);
    reset = 1'b1;
    next_cycle();
    chk("mid_rst_dbg", dbg_data, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd1);
    chk("mid_rst_rd0", rd(0), 64'd0);
    reset = 1'b0;
    run_clear(1'b0);

    set_ra(5'd13, 5'd9);
    #1 chk("r13_recleared", rd(0), 64'd0);
    chk("r9_recleared", rd(1), 64'd0);
    next_cycle();
    chk("dbg_r13_recleared", dbg_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
